// File: rtl/ex_pkg.sv
// Shared opcode, ALU-op and FSM definitions for the LEGv8 execute stage.
// Pure declarations: no latency, no backpressure.
package ex_pkg;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;
    localparam logic [10:0] OP_MUL = 11'b10011011000;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_PASS_B = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_RSVD   = 2'b11;

    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_t;

    // XZR is never a real producer, so it must never forward.
    function automatic logic fwd_hit(input logic reg_write, input logic [4:0] rd, input logic [4:0] src);
        return reg_write && (rd == src) && (rd != XZR);
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier; one accepted start yields a result in DONE after DATA_WIDTH+1 edges.
// No backpressure input: busy/done tell the stage to stall; flush aborts BUSY or DONE back to IDLE.
module mul_iter
    import ex_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  idle,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    mul_state_t            state;
    mul_state_t            state_nxt;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] acc;
    logic [CW-1:0]         cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = BUSY;
            BUSY: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are captured at accept so forwarding changes during the stall cannot leak in.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (state == IDLE && start) begin
            a_q <= a;
            b_q <= b;
            acc <= '0;
            cnt <= '0;
        end else if (state == BUSY) begin
            if (b_q[0]) begin
                acc <= acc + a_q;
            end
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
            cnt <= cnt + 1'b1;
        end
    end

    assign idle   = (state == IDLE);
    assign busy   = (state == BUSY);
    assign done   = (state == DONE);
    assign result = acc;

endmodule

// File: rtl/ex_stage.sv
// LEGv8 execute stage: forwarding, ALU, zero flag, branch target; combinational for non-MUL ops.
// MUL takes DATA_WIDTH+2 cycles and raises stall_o to freeze the front end until DONE.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  valid_i,
    input  logic [1:0]            aluop_i,
    input  logic                  alusrc_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] read_data1_i,
    input  logic [DATA_WIDTH-1:0] read_data2_i,
    input  logic [DATA_WIDTH-1:0] sign_ext_i,
    input  logic [10:0]           alu_ctrl_i,
    input  logic [4:0]            rn_i,
    input  logic [4:0]            rm_i,
    input  logic                  exmem_reg_write_i,
    input  logic                  memwb_reg_write_i,
    input  logic [4:0]            exmem_rd_i,
    input  logic [4:0]            memwb_rd_i,
    input  logic [DATA_WIDTH-1:0] exmem_result_i,
    input  logic [DATA_WIDTH-1:0] memwb_result_i,
    output logic [DATA_WIDTH-1:0] alu_result_o,
    output logic                  zero_o,
    output logic [DATA_WIDTH-1:0] store_data_o,
    output logic [DATA_WIDTH-1:0] branch_target_o,
    output logic                  valid_o,
    output logic                  stall_o
);

    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] rm_val;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] alu_comb;
    logic [DATA_WIDTH-1:0] mul_result;
    logic                  is_mul;
    logic                  mul_start;
    logic                  mul_idle;
    logic                  mul_busy;
    logic                  mul_done;

    // EX/MEM is the younger producer, so it is tested first.
    always_comb begin
        op_a = read_data1_i;
        if (fwd_hit(exmem_reg_write_i, exmem_rd_i, rn_i)) begin
            op_a = exmem_result_i;
        end else if (fwd_hit(memwb_reg_write_i, memwb_rd_i, rn_i)) begin
            op_a = memwb_result_i;
        end
    end

    always_comb begin
        rm_val = read_data2_i;
        if (fwd_hit(exmem_reg_write_i, exmem_rd_i, rm_i)) begin
            rm_val = exmem_result_i;
        end else if (fwd_hit(memwb_reg_write_i, memwb_rd_i, rm_i)) begin
            rm_val = memwb_result_i;
        end
    end

    assign op_b            = alusrc_i ? sign_ext_i : rm_val;
    assign store_data_o    = rm_val;
    assign branch_target_o = pc_i + (sign_ext_i << 2);

    always_comb begin
        alu_comb = '0;
        case (aluop_i)
            ALUOP_ADD, ALUOP_RSVD: alu_comb = op_a + op_b;
            ALUOP_PASS_B:          alu_comb = op_b;
            ALUOP_RTYPE: begin
                case (alu_ctrl_i)
                    OP_ADD:  alu_comb = op_a + op_b;
                    OP_SUB:  alu_comb = op_a - op_b;
                    OP_AND:  alu_comb = op_a & op_b;
                    OP_ORR:  alu_comb = op_a | op_b;
                    default: alu_comb = '0;
                endcase
            end
            default: alu_comb = '0;
        endcase
    end

    // Gating with reset keeps stall_o low while reset is held even if ID/EX presents a MUL.
    assign is_mul    = (aluop_i == ALUOP_RTYPE) && (alu_ctrl_i == OP_MUL);
    assign mul_start = valid_i & is_mul & ~flush_i & reset;

    mul_iter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mul (
        .clock  (clock),
        .reset  (reset),
        .start  (mul_start),
        .flush  (flush_i),
        .a      (op_a),
        .b      (op_b),
        .idle   (mul_idle),
        .busy   (mul_busy),
        .done   (mul_done),
        .result (mul_result)
    );

    assign alu_result_o = mul_done ? mul_result : alu_comb;
    assign zero_o       = (aluop_i == ALUOP_PASS_B) ? (op_b == '0) : (alu_result_o == '0);
    assign stall_o      = (mul_idle & mul_start) | mul_busy;
    assign valid_o      = mul_done ? ~flush_i : (mul_idle & ~mul_start & valid_i & ~flush_i);

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized ALU traffic against a reference model.
module tb_ex_stage;

    localparam int DW = 64;
    localparam logic [10:0] T_ADD = 11'b10001011000;
    localparam logic [10:0] T_SUB = 11'b11001011000;
    localparam logic [10:0] T_AND = 11'b10001010000;
    localparam logic [10:0] T_ORR = 11'b10101010000;
    localparam logic [10:0] T_MUL = 11'b10011011000;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush_i, valid_i, alusrc_i;
    logic [1:0]    aluop_i;
    logic [DW-1:0] pc_i, read_data1_i, read_data2_i, sign_ext_i;
    logic [10:0]   alu_ctrl_i;
    logic [4:0]    rn_i, rm_i, exmem_rd_i, memwb_rd_i;
    logic          exmem_reg_write_i, memwb_reg_write_i;
    logic [DW-1:0] exmem_result_i, memwb_result_i;
    logic [DW-1:0] alu_result_o, store_data_o, branch_target_o;
    logic          zero_o, valid_o, stall_o;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ex_stage #(.DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset), .flush_i(flush_i), .valid_i(valid_i),
        .aluop_i(aluop_i), .alusrc_i(alusrc_i), .pc_i(pc_i),
        .read_data1_i(read_data1_i), .read_data2_i(read_data2_i), .sign_ext_i(sign_ext_i),
        .alu_ctrl_i(alu_ctrl_i), .rn_i(rn_i), .rm_i(rm_i),
        .exmem_reg_write_i(exmem_reg_write_i), .memwb_reg_write_i(memwb_reg_write_i),
        .exmem_rd_i(exmem_rd_i), .memwb_rd_i(memwb_rd_i),
        .exmem_result_i(exmem_result_i), .memwb_result_i(memwb_result_i),
        .alu_result_o(alu_result_o), .zero_o(zero_o), .store_data_o(store_data_o),
        .branch_target_o(branch_target_o), .valid_o(valid_o), .stall_o(stall_o)
    );

    // Reference: start from the register file, let older then younger producer overwrite.
    function automatic logic [DW-1:0] ref_fwd(input logic [4:0] src, input logic [DW-1:0] rf);
        logic [DW-1:0] v;
        v = rf;
        if (memwb_reg_write_i && memwb_rd_i == src && src != 5'd31) v = memwb_result_i;
        if (exmem_reg_write_i && exmem_rd_i == src && src != 5'd31) v = exmem_result_i;
        return v;
    endfunction

    function automatic void ref_model(output logic [DW-1:0] res, output logic z, output logic [DW-1:0] st);
        logic [DW-1:0] a, b;
        a  = ref_fwd(rn_i, read_data1_i);
        st = ref_fwd(rm_i, read_data2_i);
        b  = alusrc_i ? sign_ext_i : st;
        if (aluop_i == 2'b01)      res = b;
        else if (aluop_i != 2'b10) res = a + b;
        else if (alu_ctrl_i == T_ADD) res = a + b;
        else if (alu_ctrl_i == T_SUB) res = a - b;
        else if (alu_ctrl_i == T_AND) res = a & b;
        else if (alu_ctrl_i == T_ORR) res = a | b;
        else if (alu_ctrl_i == T_MUL) res = a * b;
        else res = '0;
        z = (aluop_i == 2'b01) ? (b == '0) : (res == '0);
    endfunction

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    task automatic bubble();
        flush_i = 0; valid_i = 0; aluop_i = 2'b00; alusrc_i = 0; pc_i = '0;
        read_data1_i = '0; read_data2_i = '0; sign_ext_i = '0; alu_ctrl_i = '0;
        rn_i = '0; rm_i = '0; exmem_reg_write_i = 0; memwb_reg_write_i = 0;
        exmem_rd_i = '0; memwb_rd_i = '0; exmem_result_i = '0; memwb_result_i = '0;
    endtask

    task automatic drive_r(input logic [10:0] ctrl, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bubble();
        valid_i = 1; aluop_i = 2'b10; alu_ctrl_i = ctrl;
        rn_i = 5'd1; rm_i = 5'd2; read_data1_i = a; read_data2_i = b;
    endtask

    // Waits (bounded) while stall_o is high, counting stalled cycles; optionally disturbs the producers.
    task automatic wait_done(input bit disturb, output int n, output bit timeout);
        n = 0; timeout = 1;
        for (int i = 0; i < 200; i++) begin
            if (!stall_o) begin timeout = 0; break; end
            n++;
            @(posedge clock); #1;
            if (disturb) begin
                exmem_reg_write_i = 1; exmem_rd_i = ($urandom_range(0, 1) != 0) ? rn_i : rm_i;
                exmem_result_i = {$urandom, $urandom};
                memwb_reg_write_i = 1; memwb_rd_i = rn_i; memwb_result_i = {$urandom, $urandom};
                #1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 0; bubble();
        #2;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
        checks++; if (alu_result_o !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", alu_result_o); end
        checks++; if (zero_o !== 1'b1) begin errors++; $display("FAIL reset_zero: got %0b want 1", zero_o); end
        repeat (2) @(posedge clock);
        #1 reset = 1;
    endtask

    task automatic test_add();
        @(posedge clock); #1;
        drive_r(T_ADD, 64'd5, 64'd7); #1;
        checks++; if (alu_result_o !== 64'd12) begin errors++; $display("FAIL add_result: got %0d want 12", alu_result_o); end
        checks++; if (zero_o !== 1'b0) begin errors++; $display("FAIL add_zero: got %0b want 0", zero_o); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b want 1", valid_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL add_stall: got %0b want 0", stall_o); end
    endtask

    task automatic test_forwarding();
        @(posedge clock); #1;
        drive_r(T_SUB, 64'd77, 64'd4);
        rn_i = 5'd3; rm_i = 5'd4;
        exmem_reg_write_i = 1; exmem_rd_i = 5'd3; exmem_result_i = 64'd10;
        memwb_reg_write_i = 1; memwb_rd_i = 5'd3; memwb_result_i = 64'd99; #1;
        checks++; if (alu_result_o !== 64'd6) begin errors++; $display("FAIL fwd_exmem_prio: got %0d want 6", alu_result_o); end
        exmem_reg_write_i = 0; #1;
        checks++; if (alu_result_o !== 64'd95) begin errors++; $display("FAIL fwd_memwb: got %0d want 95", alu_result_o); end
        exmem_reg_write_i = 1; rn_i = 5'd31; exmem_rd_i = 5'd31; memwb_rd_i = 5'd31; read_data1_i = 64'd50; #1;
        checks++; if (alu_result_o !== 64'd46) begin errors++; $display("FAIL fwd_xzr: got %0d want 46", alu_result_o); end
        memwb_rd_i = 5'd4; memwb_result_i = 64'h1234; #1;
        checks++; if (store_data_o !== 64'h1234) begin errors++; $display("FAIL fwd_store: got %h want 1234", store_data_o); end
    endtask

    task automatic test_cbz();
        @(posedge clock); #1;
        bubble();
        valid_i = 1; aluop_i = 2'b01; rm_i = 5'd9; read_data2_i = '0;
        pc_i = 64'h100; sign_ext_i = 64'd4; #1;
        checks++; if (zero_o !== 1'b1) begin errors++; $display("FAIL cbz_zero: got %0b want 1", zero_o); end
        checks++; if (branch_target_o !== 64'h110) begin errors++; $display("FAIL cbz_target: got %h want 110", branch_target_o); end
        read_data2_i = 64'd8; #1;
        checks++; if (zero_o !== 1'b0) begin errors++; $display("FAIL cbz_nonzero: got %0b want 0", zero_o); end
    endtask

    task automatic test_random_alu();
        logic [DW-1:0] er, es;
        logic          ez;
        int            k;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock); #1;
            flush_i = ($urandom_range(0, 7) == 0); valid_i = ($urandom_range(0, 3) != 0);
            aluop_i = 2'($urandom_range(0, 3)); alusrc_i = $urandom_range(0, 1) != 0;
            pc_i = {$urandom, $urandom}; sign_ext_i = ($urandom_range(0, 7) == 0) ? '0 : {$urandom, $urandom};
            read_data1_i = {$urandom, $urandom}; read_data2_i = ($urandom_range(0, 7) == 0) ? '0 : {$urandom, $urandom};
            k = $urandom_range(0, 4);
            alu_ctrl_i = (k == 0) ? T_ADD : (k == 1) ? T_SUB : (k == 2) ? T_AND : (k == 3) ? T_ORR : 11'($urandom);
            if (alu_ctrl_i == T_MUL) alu_ctrl_i = alu_ctrl_i ^ 11'd1;
            rn_i = pick_reg(); rm_i = pick_reg();
            exmem_reg_write_i = $urandom_range(0, 1) != 0; exmem_rd_i = pick_reg(); exmem_result_i = {$urandom, $urandom};
            memwb_reg_write_i = $urandom_range(0, 1) != 0; memwb_rd_i = pick_reg(); memwb_result_i = {$urandom, $urandom};
            #1;
            ref_model(er, ez, es);
            checks++; if (alu_result_o !== er) begin errors++; $display("FAIL rnd_result[%0d]: got %h want %h", i, alu_result_o, er); end
            checks++; if (zero_o !== ez) begin errors++; $display("FAIL rnd_zero[%0d]: got %0b want %0b", i, zero_o, ez); end
            checks++; if (store_data_o !== es) begin errors++; $display("FAIL rnd_store[%0d]: got %h want %h", i, store_data_o, es); end
            checks++; if (branch_target_o !== pc_i + sign_ext_i * 4) begin errors++; $display("FAIL rnd_target[%0d]: got %h want %h", i, branch_target_o, pc_i + sign_ext_i * 4); end
            checks++; if (valid_o !== (valid_i & ~flush_i)) begin errors++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", i, valid_o, valid_i & ~flush_i); end
            checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rnd_stall[%0d]: got %0b want 0", i, stall_o); end
        end
    endtask

    task automatic test_mul();
        logic [DW-1:0] er, es;
        logic          ez;
        int            n;
        bit            to;
        @(posedge clock); #1;
        drive_r(T_MUL, '1, 64'd3);
        rn_i = 5'd5; rm_i = 5'd6; #1;
        ref_model(er, ez, es);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mul_accept_valid: got %0b want 0", valid_o); end
        wait_done(1'b1, n, to);
        checks++; if (to) begin errors++; $display("FAIL mul_timeout: stall still %0b after %0d cycles", stall_o, n); end
        checks++; if (n != 65) begin errors++; $display("FAIL mul_stall_cycles: got %0d want 65", n); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL mul_valid: got %0b want 1", valid_o); end
        checks++; if (alu_result_o !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL mul_result: got %h want fffffffffffffffd", alu_result_o); end
        checks++; if (alu_result_o !== er) begin errors++; $display("FAIL mul_model: got %h want %h", alu_result_o, er); end
        checks++; if (zero_o !== 1'b0) begin errors++; $display("FAIL mul_zero: got %0b want 0", zero_o); end
        bubble();
        @(posedge clock); #1;
        checks++; if (stall_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL mul_after_done: stall %0b valid %0b want 0 0", stall_o, valid_o); end
    endtask

    task automatic test_mul_flush();
        int seen;
        @(posedge clock); #1;
        drive_r(T_MUL, {$urandom, $urandom}, {$urandom, $urandom}); #1;
        repeat (20) @(posedge clock);
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL flush_busy_stall: got %0b want 1", stall_o); end
        flush_i = 1; #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_busy_valid: got %0b want 0", valid_o); end
        @(posedge clock); #1;
        drive_r(T_ADD, 64'd2, 64'd3); #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %0b want 0", stall_o); end
        checks++; if (valid_o !== 1'b1 || alu_result_o !== 64'd5) begin errors++; $display("FAIL flush_next_add: valid %0b result %0d want 1 5", valid_o, alu_result_o); end
        bubble();
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clock); #1;
            if (valid_o === 1'b1 || stall_o === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_result: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e1, e2, es;
        logic          ez;
        int            n;
        bit            to;
        @(posedge clock); #1;
        drive_r(T_MUL, {$urandom, $urandom}, {$urandom, $urandom}); #1;
        ref_model(e1, ez, es);
        wait_done(1'b0, n, to);
        checks++; if (to || n != 65) begin errors++; $display("FAIL b2b_first_cycles: got %0d timeout %0b want 65", n, to); end
        checks++; if (valid_o !== 1'b1 || alu_result_o !== e1) begin errors++; $display("FAIL b2b_first: valid %0b result %h want 1 %h", valid_o, alu_result_o, e1); end
        @(posedge clock); #1;
        drive_r(T_MUL, {$urandom, $urandom}, {24'd0, 8'($urandom), $urandom}); #1;
        ref_model(e2, ez, es);
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got %0b want 1", stall_o); end
        wait_done(1'b0, n, to);
        checks++; if (to || n != 65) begin errors++; $display("FAIL b2b_second_cycles: got %0d timeout %0b want 65", n, to); end
        checks++; if (valid_o !== 1'b1 || alu_result_o !== e2) begin errors++; $display("FAIL b2b_second: valid %0b result %h want 1 %h", valid_o, alu_result_o, e2); end
        bubble();
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_mul();
        @(posedge clock); #1;
        drive_r(T_MUL, {$urandom, $urandom}, {$urandom, $urandom}); #1;
        repeat (30) @(posedge clock);
        #1;
        reset = 0; bubble(); #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %0b want 0", stall_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0b want 0", valid_o); end
        @(posedge clock); #1;
        reset = 1;
        drive_r(T_ADD, 64'd1, 64'd1); #1;
        checks++; if (alu_result_o !== 64'd2 || valid_o !== 1'b1 || stall_o !== 1'b0) begin
            errors++; $display("FAIL rst_after_add: result %0d valid %0b stall %0b want 2 1 0", alu_result_o, valid_o, stall_o);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_forwarding();
        test_cbz();
        test_random_alu();
        test_mul();
        test_mul_flush();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage LEGv8 pipeline. It consumes the ID/EX pipeline register outputs and produces the ALU result, zero flag, store data and branch target that the EX/MEM register latches. It resolves RAW hazards through EX/MEM and MEM/WB forwarding. It runs MUL on an iterative shift-add multiplier, which stalls the front of the pipeline while busy.

## Interface
Parameters:
- DATA_WIDTH, 64, datapath width; must be a power of two, ≥ 8

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- flush_i  in  1  kill current EX instruction (branch taken); aborts any multiply
- valid_i  in  1  ID/EX holds a real instruction (0 = bubble)
- aluop_i  in  2  00 add (LDUR/STUR address), 01 pass B (CBZ test), 10 R-type by alu_ctrl_i, 11 reserved (treated as 00)
- alusrc_i  in  1  1: B operand = sign_ext_i, 0: forwarded Rm value
- pc_i  in  DATA_WIDTH  PC of the instruction
- read_data1_i, read_data2_i  in  DATA_WIDTH  register file values of Rn, Rm
- sign_ext_i  in  DATA_WIDTH  sign-extended immediate/offset
- alu_ctrl_i  in  11  instruction opcode field [31:21]
- rn_i, rm_i  in  5  source register numbers
- exmem_reg_write_i, memwb_reg_write_i  in  1  producer writes a register
- exmem_rd_i, memwb_rd_i  in  5  producer destinations
- exmem_result_i, memwb_result_i  in  DATA_WIDTH  producer values
- alu_result_o  out  DATA_WIDTH  result to EX/MEM
- zero_o  out  1  CBZ condition / result-is-zero
- store_data_o  out  DATA_WIDTH  forwarded Rm value (before the alusrc mux)
- branch_target_o  out  DATA_WIDTH  pc_i + (sign_ext_i << 2)
- valid_o  out  1  result is final; EX/MEM latches a real instruction
- stall_o  out  1  hold PC, IF/ID and ID/EX; EX/MEM receives a bubble

## Operation
- Forwarding per operand (A from rn_i, Rm value from rm_i):
  - EX/MEM hit: reg_write & rd == rn/rm & rd != 31 → exmem_result_i.
  - Otherwise MEM/WB hit, same rule → memwb_result_i.
  - Otherwise the register file value.
  - EX/MEM has priority when both producers hit.
- B operand = alusrc_i ? sign_ext_i : forwarded Rm.
- R-type opcodes:
  - ADD 10001011000 → A+B
  - SUB 11001011000 → A−B
  - AND 10001010000 → A&B
  - ORR 10101010000 → A|B
  - MUL 10011011000 → low DATA_WIDTH bits of A*B
  - Any other opcode → result 0.
- Arithmetic wraps modulo 2^DATA_WIDTH; no flags other than zero_o.
- zero_o = (B == 0) when aluop_i=01, else (alu_result_o == 0).
- Multiply FSM states:
  - IDLE → BUSY on valid_i & MUL & !flush_i. Captures forwarded A and B; clears the accumulator and counter.
  - BUSY: per cycle, if B[0] then acc += A; then A <<= 1, B >>= 1, cnt++. After DATA_WIDTH iterations → DONE.
  - DONE → IDLE unconditionally.
  - flush_i in BUSY or DONE → IDLE; result discarded.
- Outputs by state:
  - IDLE, non-MUL: combinational result; valid_o = valid_i & !flush_i; stall_o=0.
  - IDLE with MUL accepted: stall_o=1, valid_o=0.
  - BUSY: stall_o=1, valid_o=0.
  - DONE: alu_result_o = acc, valid_o = !flush_i, stall_o=0.
- Captured operands make the multiply immune to later EX/MEM and MEM/WB changes while stalled.
- Reset (any time, including mid-multiply): state IDLE, acc, operands and cnt = 0, stall_o=0. alu_result_o, zero_o and valid_o then follow the combinational IDLE path.

## Timing
- Non-MUL ops: 0-cycle combinational path; latched by EX/MEM at the next edge.
- MUL accepted at cycle T:
  - stall_o high in T..T+DATA_WIDTH.
  - DONE at T+DATA_WIDTH+1 with valid_o=1.
  - Total occupancy DATA_WIDTH+2 cycles (66 at default).
- During stall, upstream holds ID/EX unchanged. The IDLE re-decode is suppressed because state ≠ IDLE.
- Back-to-back MULs: the second is accepted in the IDLE cycle right after DONE.
- flush_i has no registered effect in IDLE; it only forces valid_o=0.

## Structure
- Package ex_pkg:
  - opcode constants OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_MUL
  - aluop encodings
  - FSM state enum {IDLE, BUSY, DONE}
  - XZR = 5'd31
- Sub-module mul_iter: owns the FSM, counter, accumulator, start/flush/busy/done handshake.
- ex_stage holds the forwarding muxes, ALU, zero and branch logic.

## Test plan
- ADD, no hazards, A=5, B=7 → alu_result_o=12, zero_o=0, valid_o=1, stall_o=0.
- SUB, rn=3 with EX/MEM rd=3 (value 10) and MEM/WB rd=3 (value 99), Rm=4 → result 6 (EX/MEM priority). Repeat with rd=31 → register file value used.
- CBZ: aluop=01, Rm=0 → zero_o=1; pc=0x100, imm=4 → branch_target_o=0x110.
- MUL 0xFFFF_FFFF_FFFF_FFFF × 3 → stall_o high for 65 cycles, then valid_o=1, result 0xFFFF_FFFF_FFFF_FFFD. EX/MEM inputs toggled during stall must not change the result.
- flush_i pulsed at the 20th BUSY cycle → IDLE next edge, stall_o=0, no valid result emitted.
- Reset asserted mid-multiply → immediate IDLE, stall_o=0. After release, ADD 1+1 → 2.
